// File: rtl/aead_stream_ctrl.sv
// aead_stream_ctrl: lane-serial field loader, AEAD core sequencer and LSB-first result streamer.
// Optional macro AEAD_RELEASE_GUARD_EN: decrypt data beats are forced to zero when the tag check fails.

module aead_stream_ctrl #(
  parameter int K = 128,
  parameter int L = 32,
  parameter int Y = 32,
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     in_sel,
  input  logic [W-1:0]   in_data,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_dec,
  output logic [K-1:0]   core_key,
  output logic [127:0]   core_nonce,
  output logic [L-1:0]   core_ad,
  output logic [Y-1:0]   core_din,
  output logic           core_start,
  output logic           core_dec,
  input  logic           core_done,
  input  logic [Y-1:0]   core_dout,
  input  logic [127:0]   core_tag,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic           auth_valid,
  output logic           auth_ok
);

  localparam int KB  = K / W;
  localparam int NB  = 128 / W;
  localparam int AB  = L / W;
  localparam int DB  = Y / W;
  localparam int TB  = 128 / W;
  localparam int MB0 = (KB > NB) ? KB : NB;
  localparam int MB1 = (AB > DB) ? AB : DB;
  localparam int MB  = (MB0 > MB1) ? MB0 : MB1;
  localparam int CW  = $clog2(MB + 1);
  localparam int OB  = DB + TB;
  localparam int OCW = $clog2(OB + 1);
  localparam int RW  = Y + 128;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_OUT     = 3'd3,
    S_VERDICT = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           dec_q, dec_d;
  logic           live_q;
  logic [K-1:0]   key_q, key_d;
  logic [127:0]   non_q, non_d;
  logic [L-1:0]   ad_q, ad_d;
  logic [Y-1:0]   din_q, din_d;
  logic [127:0]   tag_q, tag_d;
  logic [CW-1:0]  key_cnt_q, key_cnt_d;
  logic [CW-1:0]  non_cnt_q, non_cnt_d;
  logic [CW-1:0]  ad_cnt_q, ad_cnt_d;
  logic [CW-1:0]  din_cnt_q, din_cnt_d;
  logic [CW-1:0]  tag_cnt_q, tag_cnt_d;
  logic [RW-1:0]  ores_q, ores_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic           auth_ok_q, auth_ok_d;
  logic           auth_valid_q, auth_valid_d;
  logic           core_start_q, core_start_d;
  logic           core_dec_q, core_dec_d;

  logic           key_full_s, non_full_s, ad_full_s, din_full_s, tag_full_s;
  logic           sel_full_s, in_ready_s, cmd_ready_s, beat_s, clr_s, tag_match_s;
  logic [OCW-1:0] ob_total_s;
  logic [Y-1:0]   dout_rel_s;

  assign key_full_s  = (key_cnt_q == CW'(KB));
  assign non_full_s  = (non_cnt_q == CW'(NB));
  assign ad_full_s   = (ad_cnt_q  == CW'(AB));
  assign din_full_s  = (din_cnt_q == CW'(DB));
  assign tag_full_s  = (tag_cnt_q == CW'(TB));
  assign tag_match_s = (core_tag == tag_q);
  assign ob_total_s  = dec_q ? OCW'(DB) : OCW'(OB);

  // Fullness of the field addressed by in_sel; unknown selectors never accept.
  always_comb begin
    sel_full_s = 1'b1;
    case (in_sel)
      3'd0:    sel_full_s = key_full_s;
      3'd1:    sel_full_s = non_full_s;
      3'd2:    sel_full_s = ad_full_s;
      3'd3:    sel_full_s = din_full_s;
      3'd4:    sel_full_s = tag_full_s;
      default: sel_full_s = 1'b1;
    endcase
  end

  assign in_ready_s  = live_q && (state_q == S_IDLE) && !sel_full_s;
  assign beat_s      = in_valid && in_ready_s;
  assign cmd_ready_s = live_q && (state_q == S_IDLE) && key_full_s && non_full_s &&
                       ad_full_s && din_full_s && (!cmd_dec || tag_full_s);

  // Release guard: a failed decrypt never exposes the core's plaintext.
  always_comb begin
`ifdef AEAD_RELEASE_GUARD_EN
    if (dec_q && !tag_match_s) begin
      dout_rel_s = {Y{1'b0}};
    end else begin
      dout_rel_s = core_dout;
    end
`else
    dout_rel_s = core_dout;
`endif
  end

  // Sequencer next state, result streaming and field loading.
  always_comb begin
    state_d     = state_q;
    dec_d       = dec_q;
    key_d       = key_q;
    non_d       = non_q;
    ad_d        = ad_q;
    din_d       = din_q;
    tag_d       = tag_q;
    key_cnt_d   = key_cnt_q;
    non_cnt_d   = non_cnt_q;
    ad_cnt_d    = ad_cnt_q;
    din_cnt_d   = din_cnt_q;
    tag_cnt_d   = tag_cnt_q;
    ores_d      = ores_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    auth_ok_d   = auth_ok_q;
    clr_s       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_s) begin
          state_d   = S_START;
          dec_d     = cmd_dec;
          auth_ok_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          state_d     = S_OUT;
          auth_ok_d   = tag_match_s;
          ores_d      = {core_tag, dout_rel_s};
          out_cnt_d   = {OCW{1'b0}};
          out_valid_d = 1'b1;
          out_last_d  = (ob_total_s == OCW'(1));
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = dec_q ? S_VERDICT : S_IDLE;
            clr_s       = !dec_q;
            ores_d      = {RW{1'b0}};
            out_cnt_d   = {OCW{1'b0}};
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            ores_d     = ores_q >> W;
            out_cnt_d  = out_cnt_q + OCW'(1);
            out_last_d = ((out_cnt_q + OCW'(1)) == (ob_total_s - OCW'(1)));
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_VERDICT: begin
        state_d = S_IDLE;
        clr_s   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        clr_s   = 1'b1;
      end
    endcase

    // Loads happen only in IDLE and clears only on leaving an operation, so they never overlap.
    if (beat_s) begin
      case (in_sel)
        3'd0: begin
          key_d     = (key_q << W) | K'(in_data);
          key_cnt_d = key_cnt_q + CW'(1);
        end
        3'd1: begin
          non_d     = (non_q << W) | 128'(in_data);
          non_cnt_d = non_cnt_q + CW'(1);
        end
        3'd2: begin
          ad_d     = (ad_q << W) | L'(in_data);
          ad_cnt_d = ad_cnt_q + CW'(1);
        end
        3'd3: begin
          din_d     = (din_q << W) | Y'(in_data);
          din_cnt_d = din_cnt_q + CW'(1);
        end
        3'd4: begin
          tag_d     = (tag_q << W) | 128'(in_data);
          tag_cnt_d = tag_cnt_q + CW'(1);
        end
        default: begin
          key_cnt_d = key_cnt_q;
        end
      endcase
    end else if (clr_s) begin
      non_cnt_d = {CW{1'b0}};
      ad_cnt_d  = {CW{1'b0}};
      din_cnt_d = {CW{1'b0}};
      tag_cnt_d = {CW{1'b0}};
    end else begin
      key_cnt_d = key_cnt_q;
    end

    core_start_d = (state_d == S_START);
    auth_valid_d = (state_d == S_VERDICT);
    core_dec_d   = (state_d != S_IDLE) ? dec_d : 1'b0;
  end

  // State and datapath registers; reset wipes everything including the key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dec_q        <= 1'b0;
      live_q       <= 1'b0;
      key_q        <= {K{1'b0}};
      non_q        <= 128'd0;
      ad_q         <= {L{1'b0}};
      din_q        <= {Y{1'b0}};
      tag_q        <= 128'd0;
      key_cnt_q    <= {CW{1'b0}};
      non_cnt_q    <= {CW{1'b0}};
      ad_cnt_q     <= {CW{1'b0}};
      din_cnt_q    <= {CW{1'b0}};
      tag_cnt_q    <= {CW{1'b0}};
      ores_q       <= {RW{1'b0}};
      out_cnt_q    <= {OCW{1'b0}};
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      auth_ok_q    <= 1'b0;
      auth_valid_q <= 1'b0;
      core_start_q <= 1'b0;
      core_dec_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_q        <= dec_d;
      live_q       <= 1'b1;
      key_q        <= key_d;
      non_q        <= non_d;
      ad_q         <= ad_d;
      din_q        <= din_d;
      tag_q        <= tag_d;
      key_cnt_q    <= key_cnt_d;
      non_cnt_q    <= non_cnt_d;
      ad_cnt_q     <= ad_cnt_d;
      din_cnt_q    <= din_cnt_d;
      tag_cnt_q    <= tag_cnt_d;
      ores_q       <= ores_d;
      out_cnt_q    <= out_cnt_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      auth_ok_q    <= auth_ok_d;
      auth_valid_q <= auth_valid_d;
      core_start_q <= core_start_d;
      core_dec_q   <= core_dec_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign cmd_ready  = cmd_ready_s;
  assign core_key   = key_q;
  assign core_nonce = non_q;
  assign core_ad    = ad_q;
  assign core_din   = din_q;
  assign core_start = core_start_q;
  assign core_dec   = core_dec_q;
  assign out_valid  = out_valid_q;
  assign out_data   = ores_q[W-1:0];
  assign out_last   = out_last_q;
  assign auth_valid = auth_valid_q;
  assign auth_ok    = auth_ok_q;

endmodule

// File: tb/tb_aead_stream_ctrl.sv
// tb_aead_stream_ctrl: randomized self-checking bench for aead_stream_ctrl with a behavioural core
// and a queue-based model of the expected result stream (honours AEAD_RELEASE_GUARD_EN).

module tb_aead_stream_ctrl;

  localparam int K = 128;
  localparam int L = 32;
  localparam int Y = 32;
  localparam int W = 8;

  logic           clk        = 1'b0;
  logic           rst        = 1'b1;
  logic           in_valid   = 1'b0;
  logic           in_ready;
  logic [2:0]     in_sel     = 3'd0;
  logic [W-1:0]   in_data    = 8'h00;
  logic           cmd_valid  = 1'b0;
  logic           cmd_ready;
  logic           cmd_dec    = 1'b0;
  logic [K-1:0]   core_key;
  logic [127:0]   core_nonce;
  logic [L-1:0]   core_ad;
  logic [Y-1:0]   core_din;
  logic           core_start;
  logic           core_dec;
  logic           core_done  = 1'b0;
  logic [Y-1:0]   core_dout  = 32'h0;
  logic [127:0]   core_tag   = 128'h0;
  logic           out_valid;
  logic           out_ready  = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           auth_valid;
  logic           auth_ok;

  int             total = 0;
  int             bad   = 0;
  logic [Y-1:0]   cur_dout = 32'h0;
  logic [127:0]   cur_tag  = 128'h0;
  logic [127:0]   exp_tag  = 128'h0;
  int             core_delay = 0;
  int             core_wait  = 0;
  logic [127:0]   key_v, non_v;
  logic [31:0]    ad_v, din_v;

  aead_stream_ctrl #(.K(K), .L(L), .Y(Y), .W(W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dec(cmd_dec),
    .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad), .core_din(core_din),
    .core_start(core_start), .core_dec(core_dec),
    .core_done(core_done), .core_dout(core_dout), .core_tag(core_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .auth_valid(auth_valid), .auth_ok(auth_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Behavioural core: answers each launch after a delay with the bench's chosen results.
  always begin
    @(posedge clk);
    #1;
    if (core_start === 1'b1) begin
      core_wait = (core_delay > 0) ? core_delay : int'($urandom_range(2, 5));
      repeat (core_wait) @(negedge clk);
      core_done = 1'b1;
      core_dout = cur_dout;
      core_tag  = cur_tag;
      @(negedge clk);
      core_done = 1'b0;
      core_dout = $urandom;
      core_tag  = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic put_beat(input logic [2:0] sel, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_field(input logic [2:0] sel, input logic [127:0] val, input int nbytes);
    for (int i = nbytes - 1; i >= 0; i--) put_beat(sel, val[i*8 +: 8]);
  endtask

  task automatic do_cmd(input logic dec);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dec   = dec;
    #1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) check_eq("cmd_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_eq("core_start", core_start, 1'b1);
    check_eq("core_dec", core_dec, dec);
    @(posedge clk);
    #1;
    check_eq("core_start_pulse", core_start, 1'b0);
  endtask

  // Collects the result stream (mode 0 always ready, 1 random, 2 five-cycle stall after beat 2).
  task automatic run_out(input int mode, input logic dec);
    logic [7:0] expq[$];
    logic [7:0] b;
    logic [7:0] prev_d = 8'h00;
    logic       prev_stall = 1'b0;
    int n, got_n = 0, stall = 0, budget = 0;
    bit done = 0;
    for (int i = 0; i < Y / 8; i++) begin
      b = cur_dout[i*8 +: 8];
`ifdef AEAD_RELEASE_GUARD_EN
      if (dec && (cur_tag != exp_tag)) b = 8'h00;
`endif
      expq.push_back(b);
    end
    if (!dec) for (int j = 0; j < 16; j++) expq.push_back(cur_tag[j*8 +: 8]);
    n = expq.size();
    while (!done && budget < 400) begin
      @(negedge clk);
      budget++;
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else begin
        out_ready = !(got_n == 2 && stall < 5);
        if (!out_ready) stall++;
      end
      #1;
      if (prev_stall && out_valid) check_eq("hold_data", out_data, prev_d);
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      if (out_valid && out_ready) begin
        if (got_n < n) begin
          check_eq("beat_data", out_data, expq[got_n]);
          check_eq("beat_last", out_last, (got_n == n - 1));
        end else begin
          check_eq("extra_beat", 128'd1, 128'd0);
        end
        got_n++;
        if (out_last || got_n >= n) done = 1;
      end
    end
    if (!done) check_eq("out_timeout", 128'd0, 128'd1);
    check_eq("beat_count", got_n, n);
    @(negedge clk);
    #1;
    check_eq("out_valid_end", out_valid, 1'b0);
    check_eq("auth_valid", auth_valid, dec);
    if (dec) check_eq("auth_ok", auth_ok, (cur_tag == exp_tag));
    @(negedge clk);
    #1;
    check_eq("auth_valid_pulse", auth_valid, 1'b0);
    if (dec) check_eq("auth_ok_hold", auth_ok, (cur_tag == exp_tag));
    out_ready = 1'b0;
  endtask

  task automatic load_op_fields(input logic dec);
    non_v = {$urandom, $urandom, $urandom, $urandom};
    ad_v  = $urandom;
    din_v = $urandom;
    load_field(3'd1, non_v, 16);
    load_field(3'd2, {96'd0, ad_v}, 4);
    load_field(3'd3, {96'd0, din_v}, 4);
    if (dec) load_field(3'd4, exp_tag, 16);
    check_eq("nonce_reg", core_nonce, non_v);
    check_eq("din_reg", core_din, din_v);
  endtask

  initial begin
    logic dec_r;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_out_data", out_data, 8'h00);
    check_eq("rst_auth_valid", auth_valid, 1'b0);
    check_eq("rst_auth_ok", auth_ok, 1'b0);
    check_eq("rst_core_start", core_start, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("in_ready_live", in_ready, 1'b1);

    // Fixed-vector encrypt.
    key_v = 128'h000102030405060708090A0B0C0D0E0F;
    non_v = 128'h101112131415161718191A1B1C1D1E1F;
    load_field(3'd0, key_v, 16);
    load_field(3'd1, non_v, 16);
    load_field(3'd2, 128'hAABBCCDD, 4);
    load_field(3'd3, 128'h11223344, 4);
    check_eq("key_reg", core_key, key_v);
    check_eq("nonce_reg_fixed", core_nonce, non_v);
    check_eq("ad_reg", core_ad, 32'hAABBCCDD);
    check_eq("din_reg_fixed", core_din, 32'h11223344);
    cmd_dec = 1'b1;
    #1;
    check_eq("cmd_ready_dec_no_tag", cmd_ready, 1'b0);
    cmd_dec = 1'b0;
    #1;
    check_eq("cmd_ready_enc", cmd_ready, 1'b1);
    cur_dout = 32'hDEADBEEF;
    cur_tag  = {$urandom, $urandom, $urandom, $urandom};
    do_cmd(1'b0);
    run_out(0, 1'b0);
    check_eq("cmd_ready_after_op", cmd_ready, 1'b0);
    in_sel = 3'd0;
    #1;
    check_eq("key_persists_full", in_ready, 1'b0);
    in_sel = 3'd1;
    #1;
    check_eq("nonce_cleared", in_ready, 1'b1);

    // Decrypt with matching tag.
    exp_tag = {$urandom, $urandom, $urandom, $urandom};
    load_op_fields(1'b1);
    cur_tag  = exp_tag;
    cur_dout = $urandom;
    do_cmd(1'b1);
    run_out(1, 1'b1);

    // Decrypt with tag mismatch in bit 0.
    exp_tag = {$urandom, $urandom, $urandom, $urandom};
    load_op_fields(1'b1);
    cur_tag  = exp_tag ^ 128'd1;
    cur_dout = $urandom;
    do_cmd(1'b1);
    run_out(0, 1'b1);

    // Encrypt with a mid-stream stall, key not reloaded.
    load_op_fields(1'b0);
    cur_tag  = {$urandom, $urandom, $urandom, $urandom};
    cur_dout = $urandom;
    do_cmd(1'b0);
    run_out(2, 1'b0);

    // cmd_ready tracks the last nonce beat.
    load_field(3'd2, {96'd0, 32'h01020304}, 4);
    load_field(3'd3, {96'd0, 32'h05060708}, 4);
    non_v = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 15; i >= 1; i--) put_beat(3'd1, non_v[i*8 +: 8]);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dec   = 1'b0;
    #1;
    check_eq("cmd_ready_15_of_16", cmd_ready, 1'b0);
    put_beat(3'd1, non_v[7:0]);
    check_eq("cmd_ready_16_of_16", cmd_ready, 1'b1);
    cur_tag  = {$urandom, $urandom, $urandom, $urandom};
    cur_dout = $urandom;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_eq("core_start_36", core_start, 1'b1);
    run_out(1, 1'b0);

    // Reset while waiting on the core.
    load_op_fields(1'b0);
    core_delay = 20;
    do_cmd(1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_in_ready", in_ready, 1'b0);
    check_eq("mid_rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("mid_rst_core_start", core_start, 1'b0);
    check_eq("mid_rst_key", core_key, 128'd0);
    check_eq("mid_rst_nonce", core_nonce, 128'd0);
    repeat (30) @(negedge clk);
    #1;
    check_eq("late_done_ignored", out_valid, 1'b0);
    core_delay = 0;
    load_op_fields(1'b0);
    cmd_dec = 1'b0;
    #1;
    check_eq("cmd_ready_no_key", cmd_ready, 1'b0);
    key_v = {$urandom, $urandom, $urandom, $urandom};
    load_field(3'd0, key_v, 16);
    check_eq("cmd_ready_reloaded", cmd_ready, 1'b1);
    check_eq("key_reg_reloaded", core_key, key_v);
    cur_tag  = {$urandom, $urandom, $urandom, $urandom};
    cur_dout = $urandom;
    do_cmd(1'b0);
    run_out(1, 1'b0);

    // Random operations.
    for (int it = 0; it < 4; it++) begin
      dec_r   = 1'($urandom_range(0, 1));
      exp_tag = {$urandom, $urandom, $urandom, $urandom};
      load_op_fields(dec_r);
      cur_tag  = ($urandom_range(0, 1) == 0) ? exp_tag : (exp_tag ^ (128'd1 << $urandom_range(0, 127)));
      cur_dout = $urandom;
      do_cmd(dec_r);
      run_out(1, dec_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aead_stream_ctrl.md
AEAD_STREAM_CTRL -- requirements
Module: aead_stream_ctrl

Interface
REQ-001 SHALL have parameter K, default 128, meaning key bits.
REQ-002 SHALL have parameter L, default 32, meaning associated-data bits.
REQ-003 SHALL have parameter Y, default 32, meaning plaintext/ciphertext bits.
REQ-004 SHALL have parameter W, default 1, meaning lane width; W SHALL divide K, 128, L and Y.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  in  1  load beat valid.
REQ-008 SHALL have port in_ready  out  1  load beat accepted.
REQ-009 SHALL have port in_sel  in  3  target field: 0 key, 1 nonce, 2 AD, 3 data, 4 expected tag.
REQ-010 SHALL have port in_data  in  W  load lane.
REQ-011 SHALL have port cmd_valid  in  1  operation request.
REQ-012 SHALL have port cmd_ready  out  1  operation accepted.
REQ-013 SHALL have port cmd_dec  in  1  0 encrypt, 1 decrypt.
REQ-014 SHALL have ports core_key/core_nonce/core_ad/core_din  out  K/128/L/Y  field registers to core.
REQ-015 SHALL have ports core_start, core_dec  out  1  core launch pulse, mode.
REQ-016 SHALL have ports core_done  in  1, core_dout  in  Y, core_tag  in  128  core results.
REQ-017 SHALL have ports out_valid  out  1, out_ready  in  1, out_data  out  W, out_last  out  1  result stream.
REQ-018 SHALL have ports auth_valid  out  1, auth_ok  out  1  decrypt verdict.

Function
REQ-019 SHALL shift each accepted beat in MSB-first: field <= {field[N-W-1:0], in_data}; per-field beat counter increments.
REQ-020 SHALL drive in_ready = 1 only in IDLE and only while the in_sel field counter is below N/W; beats to a full field stall.
REQ-021 SHALL use states IDLE, START, WAIT, OUT, VERDICT; transitions: IDLE->START on cmd handshake, START->WAIT after one cycle, WAIT->OUT on core_done, OUT->VERDICT (decrypt) or IDLE (encrypt) after the last beat, VERDICT->IDLE after one cycle.
REQ-022 SHALL drive cmd_ready = 1 in IDLE only when key, nonce, AD and data are full, plus tag when cmd_dec = 1; cmd_dec is latched on handshake.
REQ-023 SHALL pulse core_start for exactly the START cycle; core_dec holds the latched mode from START until return to IDLE.
REQ-024 SHALL capture core_dout and core_tag in the core_done cycle and compute auth_ok = (core_tag == expected tag) in that cycle; out_valid rises the next cycle.
REQ-025 SHALL emit LSB-lane first: Y/W data beats, then 128/W tag beats in encrypt mode only; a beat advances only when out_valid && out_ready; out_data is held stable while stalled.
REQ-026 SHALL assert out_last on the final tag beat (encrypt) or final data beat (decrypt).
REQ-027 SHALL pulse auth_valid for the single VERDICT cycle; auth_ok remains valid until the next cmd handshake.
REQ-028 SHALL clear nonce, AD, data and tag counters on return to IDLE; the key and its counter persist across operations.
REQ-029 SHALL ignore core_done outside WAIT and ignore cmd_valid outside IDLE.

Reset
REQ-030 SHALL, on rst, go to IDLE, clear all field registers and counters, including the key, and drive in_ready, cmd_ready, core_start, out_valid, out_last, auth_valid, auth_ok and out_data to 0 in the following cycle, including mid-operation.

Configuration
REQ-031 SHALL, with AEAD_RELEASE_GUARD_EN defined, replace decrypt data beats with zeros when auth_ok = 0.
REQ-032 SHALL, without AEAD_RELEASE_GUARD_EN, emit raw core_dout regardless of auth_ok.

Verification
REQ-033 SHALL cover: W=8, load key 0x00..0F, nonce 0x10..1F, AD 0xAABBCCDD, data 0x11223344, encrypt, core_dout=0xDEADBEEF -> 4 beats EF,BE,AD,DE, then 16 tag beats, out_last on the 20th beat.
REQ-034 SHALL cover: decrypt with expected tag = core_tag -> plaintext beats, auth_valid pulse with auth_ok=1.
REQ-035 SHALL cover: decrypt with a tag mismatch in bit 0 and guard defined -> 4 zero beats, auth_ok=0.
REQ-036 SHALL cover: cmd_valid with nonce loaded to 15/16 beats -> cmd_ready=0; the 16th beat -> cmd_ready=1 in the same cycle.
REQ-037 SHALL cover: out_ready low for 5 cycles mid-stream -> out_data is stable and there is no beat loss; a second operation without key reload is accepted.
REQ-038 SHALL cover: rst asserted in WAIT -> IDLE next cycle, out_valid=0, and cmd_ready=0 until all fields are reloaded.
